// File: rtl/disp_hex_scan.sv
`default_nettype none
// ============================================================================
// Module   : disp_hex_scan
// Brief    : Multiplexed hex 7-segment scanner, frame-synchronous updates
// Revision : 1.0
// ============================================================================
module disp_hex_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_FRM_W-1:0]    c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] c_DIG_ONE  = NUM_DIGITS'(1);
    localparam logic [6:0]            c_SEG_OFF  = 7'b1111111;
    localparam logic [6:0]            c_SEG_ZERO = 7'b1000000;

    logic [c_DIV_W-1:0]      r_div_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_FRM_W-1:0]      r_frm_cnt;
    logic                    r_blink_off;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend_reg;
    logic                    r_pend;

    logic                    w_tick;
    logic                    w_wrap;
    logic [c_DIV_W-1:0]      w_div_next;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic [4*NUM_DIGITS-1:0] w_disp_next;
    logic [c_FRM_W-1:0]      w_frm_next;
    logic                    w_blink_off_next;
    logic [3:0]              w_nib;
    logic                    w_upper_zero;
    logic                    w_blank;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    f_glyph = 7'b1000000;
            4'h1:    f_glyph = 7'b1111001;
            4'h2:    f_glyph = 7'b0100100;
            4'h3:    f_glyph = 7'b0110000;
            4'h4:    f_glyph = 7'b0011001;
            4'h5:    f_glyph = 7'b0010010;
            4'h6:    f_glyph = 7'b0000010;
            4'h7:    f_glyph = 7'b1111000;
            4'h8:    f_glyph = 7'b0000000;
            4'h9:    f_glyph = 7'b0010000;
            4'hA:    f_glyph = 7'b0001000;
            4'hB:    f_glyph = 7'b0000011;
            4'hC:    f_glyph = 7'b1000110;
            4'hD:    f_glyph = 7'b0100001;
            4'hE:    f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_tick     = (r_div_cnt == c_DIV_LAST);
        w_wrap     = w_tick && (r_idx == c_IDX_LAST);
        w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;

        w_idx_next = r_idx;
        if (w_tick) begin
            w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        // New data only lands at the frame boundary so a frame is never torn
        w_disp_next = (w_wrap && r_pend) ? r_pend_reg : r_disp;

        w_frm_next       = r_frm_cnt;
        w_blink_off_next = r_blink_off;
        if (!blink_en) begin
            w_frm_next       = '0;
            w_blink_off_next = 1'b0;
        end else if (w_wrap) begin
            if (r_frm_cnt == c_FRM_LAST) begin
                w_frm_next       = '0;
                w_blink_off_next = ~r_blink_off;
            end else begin
                w_frm_next = r_frm_cnt + 1'b1;
            end
        end

        w_nib        = 4'h0;
        w_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j == int'(w_idx_next)) begin
                w_nib = w_disp_next[4*j +: 4];
            end
            if ((j >= int'(w_idx_next)) && (w_disp_next[4*j +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end

        w_blank = (blank_lz && (w_idx_next != '0) && w_upper_zero) ||
                  (blink_en && w_blink_off_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_idx       <= '0;
            r_frm_cnt   <= '0;
            r_blink_off <= 1'b0;
            r_disp      <= '0;
            r_pend_reg  <= '0;
            r_pend      <= 1'b0;
            seg         <= c_SEG_ZERO;
            dig_sel     <= c_DIG_ONE;
            frame_done  <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_next;
            r_idx       <= w_idx_next;
            r_frm_cnt   <= w_frm_next;
            r_blink_off <= w_blink_off_next;
            r_disp      <= w_disp_next;
            frame_done  <= w_wrap;

            // A load on the wrap tick overrides the clear, so it commits next frame
            if (load) begin
                r_pend_reg <= data_in;
                r_pend     <= 1'b1;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end

            if (w_tick) begin
                dig_sel <= c_DIG_ONE << w_idx_next;
                seg     <= w_blank ? c_SEG_OFF : f_glyph(w_nib);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_hex_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_hex_scan
// Brief    : Randomized self-checking bench with a cycle-count reference model
// Revision : 1.0
// ============================================================================
module tb_disp_hex_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   data_in;
    logic          load;
    logic          blank_lz;
    logic          blink_en;
    logic [6:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          frame_done;

    disp_hex_scan #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_errors = 0;

    // Model state: elapsed cycles since reset drive every timing decision
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pv;
    bit          m_pend;
    int          k_wraps;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_edge();
        int         pos;
        int         np;
        bit         tick;
        bit         wrap;
        bit         off;
        bit         blank;
        logic [3:0] nib;
        if (reset) begin
            t       = 0;
            m_disp  = '0;
            m_pv    = '0;
            m_pend  = 0;
            k_wraps = 0;
            e_seg   = glyph_tab[0];
            e_dig   = 4'b0001;
            e_fd    = 1'b0;
        end else begin
            pos  = (t / RD) % ND;
            tick = (t % RD) == RD - 1;
            wrap = tick && (pos == ND - 1);
            if (wrap && m_pend) begin
                m_disp = m_pv;
                m_pend = 0;
            end
            if (load) begin
                m_pv   = data_in;
                m_pend = 1;
            end
            if (!blink_en) k_wraps = 0;
            else if (wrap) k_wraps++;
            e_fd = wrap;
            if (tick) begin
                np    = ((t + 1) / RD) % ND;
                e_dig = 4'(1 << np);
                nib   = 4'(m_disp >> (4 * np));
                off   = blink_en && (((k_wraps / BF) % 2) == 1);
                blank = blank_lz && (np > 0) && ((m_disp >> (4 * np)) == 0);
                e_seg = (off || blank) ? 7'b1111111 : glyph_tab[nib];
            end
            t++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("dig_sel", 32'(dig_sel), 32'(e_dig));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_dig_sel", 32'(dig_sel), 32'h1);
        check("rst_seg", 32'(seg), 32'b1000000);
        check("rst_frame_done", 32'(frame_done), 32'h0);
    endtask

    initial begin
        t        = 0;
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        run(2);
        check_reset_state();
        reset = 1'b0;
        run(20);

        run_to(5);
        do_load(16'h12AF);
        run(40);

        blank_lz = 1'b1;
        run_to(2);
        do_load(16'h0005);
        run(36);
        blank_lz = 1'b0;
        run(32);

        run_to(1);
        do_load(16'h1111);
        run_to(8);
        do_load(16'h2222);
        run(20);
        run_to(15);
        do_load(16'h3333);
        run(40);

        run_to(3);
        do_load(16'h8888);
        run_to(0);
        blink_en = 1'b1;
        run(100);
        blink_en = 1'b0;
        run(20);

        run_to(6);
        do_load(16'h4444);
        run(2);
        reset = 1'b1;
        cycle();
        check_reset_state();
        reset = 1'b0;
        run(40);

        for (int i = 0; i < 3000; i++) begin
            load    = ($urandom % 16) == 0;
            data_in = 16'($urandom);
            if (($urandom % 64) == 0) blank_lz = ~blank_lz;
            if (($urandom % 200) == 0) blink_en = ~blink_en;
            reset   = ($urandom % 500) == 0;
            cycle();
        end
        load  = 1'b0;
        reset = 1'b0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_hex_scan.md
DISP_HEX_SCAN -- requirements
Module: disp_hex_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of hex digits scanned (range 1-8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit is driven (min 2).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, giving the frames per blink phase (min 1).
REQ-004 The block SHALL have input clk, width 1: the single system clock, rising-edge.
REQ-005 The block SHALL have input reset, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have input data_in, width 4*NUM_DIGITS: the value to show; nibble k maps to digit k, and digit 0 is the least significant.
REQ-007 The block SHALL have input load, width 1: a one-cycle strobe that captures data_in.
REQ-008 The block SHALL have input blank_lz, width 1: when high, leading zeros are blanked.
REQ-009 The block SHALL have input blink_en, width 1: when high, the whole display blinks.
REQ-010 The block SHALL have output seg, width 7: segment drive in order gfedcba, active-low (0 = lit).
REQ-011 The block SHALL have output dig_sel, width NUM_DIGITS: a one-hot, active-high digit enable.
REQ-012 The block SHALL have output frame_done, width 1: a one-cycle pulse that marks the end of each scan frame.

Function
REQ-013 A divider count div_cnt SHALL run 0..REFRESH_DIV-1 and wrap; the cycle with div_cnt=REFRESH_DIV-1 is a "tick".
REQ-014 On each tick, digit index idx SHALL advance by one and wrap from NUM_DIGITS-1 to 0; the tick where idx wraps is the "wrap tick".
REQ-015 All outputs SHALL be registered; seg and dig_sel SHALL reflect the new idx on the cycle after the tick, giving one cycle of latency.
REQ-016 dig_sel SHALL equal 1<<idx at all times and SHALL never be all-zero or multi-hot, including while blanking.
REQ-017 seg SHALL be the active-low hex glyph of disp_reg nibble idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 load SHALL copy data_in into pend_reg and set the pend flag; a later load before commit SHALL overwrite pend_reg, so the last load wins.
REQ-019 On the wrap tick, if pend=1, disp_reg SHALL take pend_reg and pend SHALL clear, so the display never changes mid-frame.
REQ-020 If load coincides with the wrap tick, the old pend_reg SHALL commit, the new data_in SHALL go to pend_reg, and pend SHALL remain 1 so it commits at the next wrap.
REQ-021 frame_done SHALL be 1 on the cycle after each wrap tick and 0 otherwise.
REQ-022 With blank_lz=1, digit k>0 SHALL show seg=1111111 when disp_reg nibbles k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-023 A frame counter SHALL count wrap ticks 0..BLINK_FRAMES-1, and a blink phase SHALL toggle each time it wraps.
REQ-024 While blink_en=1 and the blink phase is "off", seg SHALL be 1111111 while scanning continues.
REQ-025 When blink_en=0, the frame counter and phase SHALL be held at 0/"on"; asserting blink_en SHALL start with a full on-phase of BLINK_FRAMES frames.
REQ-026 blank_lz and blink_en SHALL take effect on the next digit update, with no glitch on dig_sel.

Reset
REQ-027 reset SHALL be synchronous and active-high, and SHALL override load and ticks in the same cycle.
REQ-028 On reset, div_cnt, idx, the frame counter, disp_reg, pend_reg and pend SHALL go to 0, and the blink phase to "on".
REQ-029 On the cycle after reset, outputs SHALL be dig_sel=…0001, seg=1000000, frame_done=0.
REQ-030 Reset asserted mid-frame SHALL discard pending data and restart the scan at digit 0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset then run 20 cycles -> dig_sel sequence 0001,0010,0100,1000,0001 with 4 cycles each, all seg=1000000, and one frame_done at the wrap.
REQ-032 Load 16'h12AF mid-frame -> the current frame is unchanged; the next frame shows digit0..3 = 0001110, 0001000, 0100100, 1111001.
REQ-033 Load 16'h0005 with blank_lz=1 -> digits 1-3 show 1111111 and digit 0 shows 0010010; with blank_lz=0, digits 1-3 show 1000000.
REQ-034 Load 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed; load on the wrap-tick cycle is displayed one frame later.
REQ-035 blink_en=1 with value 16'h8888 -> 2 frames with seg=0000000, then 2 frames with seg=1111111, repeating, while dig_sel keeps scanning.
REQ-036 Assert reset mid-frame with a load pending -> the next cycle shows dig_sel=0001, seg=1000000, and the pending value is never shown.
